// File: rtl/pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl
//   Central sequencer for the 5-stage MIPS pipeline. It produces the freeze
//   and flush controls for the IF, ID, EXE and MEM stage registers, the EXE
//   forwarding selects, a multi-cycle data-memory wait FSM and a saturating
//   stall performance counter.
//
// Parameters
//   MEM_LAT : total cycles a data-memory access occupies MEM (1..15)
//   CNT_W   : width of the stall performance counter
//
// Ports
//   clk, rst          : clock (rising edge), asynchronous active-low reset
//   fwd_en            : 1 = forwarding on, 0 = stall on every RAW dependency
//   id_*              : source registers of the instruction in ID
//   ex_*              : fields held in the ID/EX register
//   mem_*             : fields held in the EXE/MEM register
//   wb_*              : fields held in the MEM/WB register
//   branch_taken      : branch resolved taken in EXE
//   freeze_*/flush_*  : stage register hold / clear controls
//   mem_start         : one-cycle pulse that launches a data-memory access
//   sel_a, sel_b      : ALU operand selects (0 regfile, 1 EXE/MEM, 2 WB)
//   stall_cnt         : saturating count of cycles with freeze_if high
// ---------------------------------------------------------------------------
module pipe_hazard_ctrl #(
  parameter int MEM_LAT = 4,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fwd_en,
  input  logic [4:0]       id_src1,
  input  logic [4:0]       id_src2,
  input  logic             id_two_src,
  input  logic [4:0]       ex_src1,
  input  logic [4:0]       ex_src2,
  input  logic [4:0]       ex_dest,
  input  logic             ex_wb_en,
  input  logic             ex_mem_r_en,
  input  logic [4:0]       mem_dest,
  input  logic             mem_wb_en,
  input  logic             mem_r_en,
  input  logic             mem_w_en,
  input  logic [4:0]       wb_dest,
  input  logic             wb_wb_en,
  input  logic             branch_taken,
  output logic             freeze_if,
  output logic             freeze_id,
  output logic             freeze_exe,
  output logic             freeze_mem,
  output logic             flush_if,
  output logic             flush_id,
  output logic             mem_start,
  output logic [1:0]       sel_a,
  output logic [1:0]       sel_b,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  // Index of the final access cycle, counted from 0 at the IDLE cycle.
  localparam logic [3:0] LAST_CNT = 4'(MEM_LAT - 1);

  state_t     state_reg, state_next;
  logic [3:0] cnt_reg, cnt_next;
  logic       mem_acc;
  logic       mem_frz;
  logic       start_c;
  logic       hz;

  logic [CNT_W-1:0] stall_cnt_reg;

  assign mem_acc = mem_r_en | mem_w_en;

  // -------------------------------------------------------------------------
  // Memory wait FSM: the launch cycle in IDLE is the first of MEM_LAT cycles,
  // so WAIT only has to cover cycles 1..MEM_LAT-1 and releases on the last.
  // -------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    mem_frz    = 1'b0;
    start_c    = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (mem_acc) begin
          start_c = 1'b1;
          if (MEM_LAT > 1) begin
            mem_frz    = 1'b1;
            cnt_next   = 4'd1;
            state_next = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_reg < LAST_CNT) begin
          mem_frz  = 1'b1;
          cnt_next = cnt_reg + 4'd1;
        end else begin
          cnt_next   = 4'd0;
          state_next = ST_IDLE;
        end
      end
      default: begin
        cnt_next   = 4'd0;
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= 4'd0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // -------------------------------------------------------------------------
  // Per-source hazard match (ID side) and forwarding select (EXE side).
  // Register 0 never creates a dependency.
  // -------------------------------------------------------------------------
  logic [4:0] id_src [2];
  logic [4:0] ex_src [2];
  logic [1:0] id_use;
  logic [1:0] ex_hit;
  logic [1:0] mem_hit;
  logic [1:0] fwd_sel [2];

  assign id_src[0] = id_src1;
  assign id_src[1] = id_src2;
  assign ex_src[0] = ex_src1;
  assign ex_src[1] = ex_src2;
  assign id_use    = {id_two_src, 1'b1};

  for (genvar gi = 0; gi < 2; gi++) begin : g_src
    assign ex_hit[gi]  = id_use[gi] && (id_src[gi] != 5'd0) && (id_src[gi] == ex_dest);
    assign mem_hit[gi] = id_use[gi] && (id_src[gi] != 5'd0) && (id_src[gi] == mem_dest);

    // EXE/MEM is the younger producer, so it wins over MEM/WB.
    assign fwd_sel[gi] =
        (!fwd_en || ex_src[gi] == 5'd0)              ? 2'd0 :
        (mem_wb_en && mem_dest == ex_src[gi])        ? 2'd1 :
        (wb_wb_en  && wb_dest  == ex_src[gi])        ? 2'd2 : 2'd0;
  end

  // With forwarding only a load in EXE cannot be bypassed in time; without it
  // any pending writer in EXE or MEM forces a stall.
  assign hz = fwd_en ? (ex_mem_r_en && ex_wb_en && (|ex_hit))
                     : ((ex_wb_en && (|ex_hit)) || (mem_wb_en && (|mem_hit)));

  // -------------------------------------------------------------------------
  // Outputs. Stage registers give flush priority over freeze, so flushes are
  // masked while the memory freeze is active. All outputs are forced low
  // while reset is held.
  // -------------------------------------------------------------------------
  assign freeze_mem = rst & mem_frz;
  assign freeze_exe = rst & mem_frz;
  assign freeze_id  = rst & mem_frz;
  assign freeze_if  = rst & (mem_frz | hz);
  assign flush_if   = rst & ~mem_frz & branch_taken;
  assign flush_id   = rst & ~mem_frz & (branch_taken | hz);
  assign mem_start  = rst & start_c;
  assign sel_a      = rst ? fwd_sel[0] : 2'd0;
  assign sel_b      = rst ? fwd_sel[1] : 2'd0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_reg <= '0;
    end else if (freeze_if && (stall_cnt_reg != {CNT_W{1'b1}})) begin
      stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);
    end
  end

  assign stall_cnt = stall_cnt_reg;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipe_hazard_ctrl
//   Directed bench for pipe_hazard_ctrl. A main instance (MEM_LAT=4,
//   CNT_W=16) and a small instance (MEM_LAT=1, CNT_W=4, same inputs) are
//   driven together; the small one exercises single-cycle access and counter
//   saturation within a short run.
// ---------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;

  logic       clk;
  logic       rst;
  logic       fwd_en;
  logic [4:0] id_src1, id_src2;
  logic       id_two_src;
  logic [4:0] ex_src1, ex_src2, ex_dest;
  logic       ex_wb_en, ex_mem_r_en;
  logic [4:0] mem_dest;
  logic       mem_wb_en, mem_r_en, mem_w_en;
  logic [4:0] wb_dest;
  logic       wb_wb_en;
  logic       branch_taken;

  logic        freeze_if, freeze_id, freeze_exe, freeze_mem;
  logic        flush_if, flush_id, mem_start;
  logic [1:0]  sel_a, sel_b;
  logic [15:0] stall_cnt;

  logic        freeze_if_s, freeze_id_s, freeze_exe_s, freeze_mem_s;
  logic        flush_if_s, flush_id_s, mem_start_s;
  logic [1:0]  sel_a_s, sel_b_s;
  logic [3:0]  stall_cnt_s;

  int errors = 0;
  int checks = 0;

  pipe_hazard_ctrl #(.MEM_LAT(4), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .fwd_en(fwd_en),
    .id_src1(id_src1), .id_src2(id_src2), .id_two_src(id_two_src),
    .ex_src1(ex_src1), .ex_src2(ex_src2), .ex_dest(ex_dest),
    .ex_wb_en(ex_wb_en), .ex_mem_r_en(ex_mem_r_en),
    .mem_dest(mem_dest), .mem_wb_en(mem_wb_en), .mem_r_en(mem_r_en), .mem_w_en(mem_w_en),
    .wb_dest(wb_dest), .wb_wb_en(wb_wb_en), .branch_taken(branch_taken),
    .freeze_if(freeze_if), .freeze_id(freeze_id), .freeze_exe(freeze_exe), .freeze_mem(freeze_mem),
    .flush_if(flush_if), .flush_id(flush_id), .mem_start(mem_start),
    .sel_a(sel_a), .sel_b(sel_b), .stall_cnt(stall_cnt)
  );

  pipe_hazard_ctrl #(.MEM_LAT(1), .CNT_W(4)) dut_s (
    .clk(clk), .rst(rst), .fwd_en(fwd_en),
    .id_src1(id_src1), .id_src2(id_src2), .id_two_src(id_two_src),
    .ex_src1(ex_src1), .ex_src2(ex_src2), .ex_dest(ex_dest),
    .ex_wb_en(ex_wb_en), .ex_mem_r_en(ex_mem_r_en),
    .mem_dest(mem_dest), .mem_wb_en(mem_wb_en), .mem_r_en(mem_r_en), .mem_w_en(mem_w_en),
    .wb_dest(wb_dest), .wb_wb_en(wb_wb_en), .branch_taken(branch_taken),
    .freeze_if(freeze_if_s), .freeze_id(freeze_id_s), .freeze_exe(freeze_exe_s), .freeze_mem(freeze_mem_s),
    .flush_if(flush_if_s), .flush_id(flush_id_s), .mem_start(mem_start_s),
    .sel_a(sel_a_s), .sel_b(sel_b_s), .stall_cnt(stall_cnt_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       fwd;
    logic [4:0] id1;
    logic [4:0] id2;
    logic       two;
    logic [4:0] exs1;
    logic [4:0] exs2;
    logic [4:0] exd;
    logic       exwb;
    logic       exld;
    logic [4:0] memd;
    logic       memwb;
    logic [4:0] wbd;
    logic       wbwb;
    logic       br;
    logic       e_fif;
    logic       e_flif;
    logic       e_flid;
    logic [1:0] e_sa;
    logic [1:0] e_sb;
  } vec_t;

  localparam int NV = 16;
  vec_t tv [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    fwd_en = 1'b1; id_src1 = '0; id_src2 = '0; id_two_src = 1'b0;
    ex_src1 = '0; ex_src2 = '0; ex_dest = '0; ex_wb_en = 1'b0; ex_mem_r_en = 1'b0;
    mem_dest = '0; mem_wb_en = 1'b0; mem_r_en = 1'b0; mem_w_en = 1'b0;
    wb_dest = '0; wb_wb_en = 1'b0; branch_taken = 1'b0;
  endtask

  function automatic logic [31:0] all_outs();
    return 32'({freeze_if, freeze_id, freeze_exe, freeze_mem, flush_if, flush_id,
                mem_start, sel_a, sel_b});
  endfunction

  initial begin
    int starts;
    int frz;

    //            fwd id1 id2 two exs1 exs2 exd exwb exld memd memwb wbd wbwb br  fif flif flid sa sb
    tv[0]  = '{1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0};
    tv[1]  = '{1'b1, 5'd5, 5'd0, 1'b0, 5'd0, 5'd0, 5'd5, 1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'd0, 2'd0};
    tv[2]  = '{1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0};
    tv[3]  = '{1'b1, 5'd5, 5'd0, 1'b0, 5'd0, 5'd0, 5'd5, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0};
    tv[4]  = '{1'b1, 5'd6, 5'd5, 1'b0, 5'd0, 5'd0, 5'd5, 1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0};
    tv[5]  = '{1'b1, 5'd6, 5'd5, 1'b1, 5'd0, 5'd0, 5'd5, 1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'd0, 2'd0};
    tv[6]  = '{1'b0, 5'd1, 5'd7, 1'b1, 5'd7, 5'd7, 5'd0, 1'b0, 1'b0, 5'd7, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'd0, 2'd0};
    tv[7]  = '{1'b0, 5'd1, 5'd7, 1'b0, 5'd7, 5'd7, 5'd0, 1'b0, 1'b0, 5'd7, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0};
    tv[8]  = '{1'b0, 5'd9, 5'd0, 1'b0, 5'd0, 5'd0, 5'd9, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'd0, 2'd0};
    tv[9]  = '{1'b1, 5'd0, 5'd0, 1'b0, 5'd3, 5'd0, 5'd0, 1'b0, 1'b0, 5'd3, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 2'd0};
    tv[10] = '{1'b1, 5'd0, 5'd0, 1'b0, 5'd3, 5'd0, 5'd0, 1'b0, 1'b0, 5'd3, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 2'd0};
    tv[11] = '{1'b1, 5'd0, 5'd0, 1'b0, 5'd2, 5'd4, 5'd0, 1'b0, 1'b0, 5'd4, 1'b1, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 2'd1};
    tv[12] = '{1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0};
    tv[13] = '{1'b1, 5'd5, 5'd0, 1'b0, 5'd0, 5'd0, 5'd5, 1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 2'd0, 2'd0};
    tv[14] = '{1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 2'd0, 2'd0};
    tv[15] = '{1'b1, 5'd8, 5'd0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd8, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0};

    // ---------------- reset state ----------------
    rst = 1'b0;
    clear_inputs();
    repeat (3) next_cycle();
    @(negedge clk);
    chk("reset_outs", all_outs(), 32'd0);
    chk("reset_cnt", 32'(stall_cnt), 32'd0);
    next_cycle();
    rst = 1'b1;

    // ---------------- table-driven combinational vectors ----------------
    for (int i = 0; i < NV; i++) begin
      fwd_en = tv[i].fwd; id_src1 = tv[i].id1; id_src2 = tv[i].id2; id_two_src = tv[i].two;
      ex_src1 = tv[i].exs1; ex_src2 = tv[i].exs2; ex_dest = tv[i].exd;
      ex_wb_en = tv[i].exwb; ex_mem_r_en = tv[i].exld;
      mem_dest = tv[i].memd; mem_wb_en = tv[i].memwb;
      wb_dest = tv[i].wbd; wb_wb_en = tv[i].wbwb; branch_taken = tv[i].br;
      @(negedge clk);
      $display("vec %0d: fif=%0b flif=%0b flid=%0b sa=%0d sb=%0d", i,
               freeze_if, flush_if, flush_id, sel_a, sel_b);
      chk($sformatf("vec%0d", i), all_outs(),
          32'({tv[i].e_fif, 3'b000, tv[i].e_flif, tv[i].e_flid, 1'b0, tv[i].e_sa, tv[i].e_sb}));
      next_cycle();
    end
    clear_inputs();
    chk("cnt_after_table", 32'(stall_cnt), 32'd5);
    chk("cnt_s_after_table", 32'(stall_cnt_s), 32'd5);

    // ---------------- single load, MEM_LAT=4 ----------------
    mem_r_en = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      $display("load cyc %0d: start=%0b frz=%0b%0b%0b%0b", k, mem_start,
               freeze_if, freeze_id, freeze_exe, freeze_mem);
      chk($sformatf("load_start%0d", k), 32'(mem_start), 32'(k == 0));
      chk($sformatf("load_frz%0d", k), 32'({freeze_if, freeze_id, freeze_exe, freeze_mem}),
          (k < 3) ? 32'hF : 32'h0);
      if (k == 0) begin
        chk("lat1_start", 32'({mem_start_s, freeze_if_s}), 32'b10);
      end
      next_cycle();
    end
    mem_r_en = 1'b0;

    // ---------------- two back-to-back stores ----------------
    mem_w_en = 1'b1;
    starts = 0;
    frz = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      starts += int'(mem_start);
      frz += int'(freeze_mem);
      next_cycle();
    end
    mem_w_en = 1'b0;
    $display("stores: starts=%0d freeze_cycles=%0d", starts, frz);
    chk("b2b_starts", 32'(starts), 32'd2);
    chk("b2b_frz", 32'(frz), 32'd6);
    @(negedge clk);
    chk("b2b_idle", 32'({mem_start, freeze_if}), 32'd0);
    next_cycle();

    // ---------------- branch during freeze ----------------
    mem_r_en = 1'b1;
    branch_taken = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      $display("br cyc %0d: flush_if=%0b flush_id=%0b", k, flush_if, flush_id);
      chk($sformatf("br_flush%0d", k), 32'({flush_if, flush_id}), (k == 3) ? 32'b11 : 32'b00);
      if (k == 0) begin
        chk("br_flush_lat1", 32'({flush_if_s, flush_id_s}), 32'b11);
      end
      next_cycle();
    end
    clear_inputs();
    chk("cnt_after_mem", 32'(stall_cnt), 32'd17);
    chk("cnt_s_after_mem", 32'(stall_cnt_s), 32'd5);

    // ---------------- reset mid-wait ----------------
    mem_r_en = 1'b1;
    next_cycle();
    next_cycle();                 // FSM now in WAIT
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_outs", all_outs(), 32'd0);
    chk("rst_mid_cnt", 32'(stall_cnt), 32'd0);
    next_cycle();
    mem_r_en = 1'b0;
    next_cycle();
    rst = 1'b1;
    @(negedge clk);
    chk("rel_outs", all_outs(), 32'd0);
    next_cycle();
    @(negedge clk);
    chk("rel_idle", all_outs(), 32'd0);
    next_cycle();
    mem_r_en = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (k == 0) begin
        chk("rel_new_start", 32'({mem_start, freeze_if}), 32'b11);
      end
      next_cycle();
    end
    mem_r_en = 1'b0;
    chk("cnt_after_rel", 32'(stall_cnt), 32'd3);

    // ---------------- counter saturation ----------------
    ex_mem_r_en = 1'b1; ex_wb_en = 1'b1; ex_dest = 5'd5; id_src1 = 5'd5;
    repeat (15) @(posedge clk);
    #1;
    chk("sat_reach", 32'(stall_cnt_s), 32'd15);
    repeat (5) @(posedge clk);
    #1;
    $display("sat: cnt=%0d cnt_s=%0d", stall_cnt, stall_cnt_s);
    chk("sat_hold", 32'(stall_cnt_s), 32'd15);
    chk("cnt_main_23", 32'(stall_cnt), 32'd23);
    clear_inputs();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
